// File: rtl/e_alu_mdu_pkg.sv
// e_alu_mdu_pkg: ALU/MDU opcode encodings, FSM states and op-class helpers
package e_alu_mdu_pkg;
    typedef enum logic [3:0] {
        ALU_AND, ALU_OR, ALU_XOR, ALU_NOR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_SLTU,
        ALU_SLL, ALU_SRL, ALU_SRA, ALU_LUI
    } alu_op_e;
    typedef enum logic [2:0] {
        MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU, MDU_MTHI, MDU_MTLO, MDU_MFHI, MDU_MFLO
    } mdu_op_e;
    typedef enum logic {S_IDLE, S_RUN} mdu_state_e;
    function automatic logic is_mul(mdu_op_e op);
        return op == MDU_MULT || op == MDU_MULTU;
    endfunction
    function automatic logic is_long(mdu_op_e op);
        return op inside {MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU};
    endfunction
endpackage

// File: rtl/e_alu_mdu_if.sv
// e_alu_mdu_if: execute-stage operand/result bundle; overflow exists only with ALU_OVF_EN
interface e_alu_mdu_if import e_alu_mdu_pkg::*; #(parameter int WIDTH = 32);
    logic [WIDTH-1:0] src_a, src_b, alu_result, hi, lo;
    logic [4:0] shamt;
    alu_op_e alu_control;
    mdu_op_e mdu_op;
    logic start, busy;
`ifdef ALU_OVF_EN
    logic overflow;
`endif
    modport master (
        output src_a, src_b, shamt, alu_control, start, mdu_op,
`ifdef ALU_OVF_EN
        input overflow,
`endif
        input alu_result, busy, hi, lo
    );
    modport slave (
        input src_a, src_b, shamt, alu_control, start, mdu_op,
`ifdef ALU_OVF_EN
        output overflow,
`endif
        output alu_result, busy, hi, lo
    );
endinterface

// File: rtl/e_alu_mdu_mdu_core.sv
// mdu_core: multi-cycle multiply/divide FSM, operand latches and HI/LO registers
module mdu_core import e_alu_mdu_pkg::*; #(
    parameter int WIDTH = 32,
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  mdu_op_e          op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int MAXC = MUL_CYCLES > DIV_CYCLES ? MUL_CYCLES : DIV_CYCLES;
    localparam int CW = $clog2(MAXC + 1);
    mdu_state_e state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    mdu_op_e op_q;
    logic [WIDTH-1:0] a_q, b_q, ma, mb, mq, mr, quo, rem;
    logic [2*WIDTH-1:0] prod, res;
    logic launch, done, na, nb;
    assign busy = state == S_RUN;
    // launch/finish decode and down-counter next value; starts while busy are dropped
    always_comb begin
        launch = start && !busy && is_long(op);
        done = busy && cnt == '0;
        state_n = launch ? S_RUN : done ? S_IDLE : state;
        cnt_n = launch ? (is_mul(op) ? CW'(MUL_CYCLES - 1) : CW'(DIV_CYCLES - 1))
              : (busy && !done) ? cnt - 1'b1 : cnt;
    end
    // product and sign-magnitude divide from the latched operands, with zero-divisor override
    always_comb begin
        na = op_q == MDU_DIV && a_q[WIDTH-1];
        nb = op_q == MDU_DIV && b_q[WIDTH-1];
        ma = na ? -a_q : a_q;
        mb = nb ? -b_q : b_q;
        mq = ma / mb;
        mr = ma % mb;
        quo = (na ^ nb) ? -mq : mq;
        rem = na ? -mr : mr;
        prod = op_q == MDU_MULT ? {{WIDTH{a_q[WIDTH-1]}}, a_q} * {{WIDTH{b_q[WIDTH-1]}}, b_q}
                                : {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};
        res = is_mul(op_q) ? prod : b_q == '0 ? {a_q, {WIDTH{1'b1}}} : {rem, quo};
    end
    // FSM state and counter registers
    always_ff @(posedge clk) begin
        state <= reset ? S_IDLE : state_n;
        cnt <= reset ? '0 : cnt_n;
    end
    // operand capture on launch, HI/LO write on completion or MTHI/MTLO
    always_ff @(posedge clk) begin
        if (reset) begin
            op_q <= MDU_MULT;
            a_q <= '0;
            b_q <= '0;
            hi <= '0;
            lo <= '0;
        end else begin
            if (launch) begin
                op_q <= op;
                a_q <= src_a;
                b_q <= src_b;
            end
            if (done) {hi, lo} <= res;
            else if (start && !busy && op == MDU_MTHI) hi <= src_a;
            else if (start && !busy && op == MDU_MTLO) lo <= src_a;
        end
    end
endmodule

// File: rtl/e_alu_mdu.sv
// e_alu_mdu: execute-stage ALU plus MDU with HI/LO; ALU_OVF_EN adds the overflow output
module e_alu_mdu import e_alu_mdu_pkg::*; #(
    parameter int WIDTH = 32,
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input logic        clk,
    input logic        reset,
    e_alu_mdu_if.slave bus
);
    localparam int SW = $clog2(WIDTH);
    logic [WIDTH-1:0] a, b, sum, diff, alu;
    logic [SW-1:0] sh;
    assign a = bus.src_a;
    assign b = bus.src_b;
    mdu_core #(.WIDTH(WIDTH), .MUL_CYCLES(MUL_CYCLES), .DIV_CYCLES(DIV_CYCLES)) u_mdu (
        .clk(clk), .reset(reset), .start(bus.start), .op(bus.mdu_op),
        .src_a(a), .src_b(b), .busy(bus.busy), .hi(bus.hi), .lo(bus.lo)
    );
    // combinational ALU; unlisted codes produce zero
    always_comb begin
        sh = bus.shamt[SW-1:0];
        sum = a + b;
        diff = a - b;
        case (bus.alu_control)
            ALU_AND:  alu = a & b;
            ALU_OR:   alu = a | b;
            ALU_XOR:  alu = a ^ b;
            ALU_NOR:  alu = ~(a | b);
            ALU_ADD:  alu = sum;
            ALU_SUB:  alu = diff;
            ALU_SLT:  alu = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
            ALU_SLTU: alu = {{(WIDTH-1){1'b0}}, a < b};
            ALU_SLL:  alu = a << sh;
            ALU_SRL:  alu = a >> sh;
            ALU_SRA:  alu = $signed(a) >>> sh;
            ALU_LUI:  alu = b << 16;
            default:  alu = '0;
        endcase
    end
    assign bus.alu_result = bus.mdu_op == MDU_MFHI ? bus.hi : bus.mdu_op == MDU_MFLO ? bus.lo : alu;
`ifdef ALU_OVF_EN
    assign bus.overflow = (bus.alu_control == ALU_ADD && a[WIDTH-1] == b[WIDTH-1] && sum[WIDTH-1] != a[WIDTH-1])
                       || (bus.alu_control == ALU_SUB && a[WIDTH-1] != b[WIDTH-1] && diff[WIDTH-1] != a[WIDTH-1]);
`endif
endmodule
